// File: rtl/bcd_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the double-dabble binary-to-BCD converter.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int unsigned DIGIT_W     = 4;
   localparam logic [3:0]  ADD3_THRESH = 4'd5;

   // True when every WIDTH-bit binary value fits in DIGITS decimal digits.
   // Widths beyond 63 bits are rejected rather than evaluated.
   function automatic bit range_ok(input int unsigned width, input int unsigned digits);
      longint unsigned max_bin;
      longint unsigned max_dec;
      if (width > 63) return 1'b0;
      max_bin = (64'd1 << width) - 64'd1;
      max_dec = 64'd1;
      for (int unsigned i = 0; i < digits && i < 19; i++) max_dec = max_dec * 64'd10;
      max_dec = max_dec - 64'd1;
      return max_bin <= max_dec;
   endfunction

endpackage

// File: rtl/bcd_dabble_if.sv
`timescale 1ns/1ps
// Handshake and result bundle between the binary source, the converter and the display stage.
interface bcd_dabble_if
   import bcd_pkg::*;
#(
   parameter int WIDTH  = 10,
   parameter int DIGITS = 4
);
   logic [WIDTH-1:0]          in_data;
   logic                      in_valid;
   logic                      in_ready;
   logic [DIGIT_W*DIGITS-1:0] bcd_out;
   logic [DIGITS-1:0]         blank_out;
   logic                      out_valid;

   modport master (
      output in_data, in_valid,
      input  in_ready, bcd_out, blank_out, out_valid
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, bcd_out, blank_out, out_valid
   );
endinterface

// File: rtl/bcd_digit_adj.sv
`timescale 1ns/1ps
// Per-digit double-dabble correction: add 3 to any digit of 5 or more before the shift.
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit_in,
   output logic [DIGIT_W-1:0] digit_out
);

   assign digit_out = (digit_in >= ADD3_THRESH) ? digit_in + 4'd3 : digit_in;

endmodule

// File: rtl/bcd_dabble.sv
`timescale 1ns/1ps
// Sequential binary-to-BCD converter (shift-and-add-3) with leading-zero mask.
// state | meaning
// IDLE  | ready for a new value (once out of reset)
// SHIFT | WIDTH adjust-and-shift iterations
// DONE  | latch digits and blank mask, pulse out_valid next cycle
module bcd_dabble
   import bcd_pkg::*;
#(
   parameter int WIDTH  = 10,
   parameter int DIGITS = 4
)(
   input logic         clk,
   input logic         rst_n,
   bcd_dabble_if.slave bus
);

   localparam int BCD_W = DIGIT_W * DIGITS;
   localparam int SR_W  = BCD_W + WIDTH;
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WIDTH - 1);
   localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

   if (!range_ok(WIDTH, DIGITS)) begin : g_range_chk
      $error("bcd_dabble: DIGITS too small to hold 2**WIDTH-1");
   end

   state_t            state;
   state_t            state_nxt;
   logic              ready_en;
   logic              in_ready;
   logic              accept;
   logic [CNT_W-1:0]  cnt;
   logic [SR_W-1:0]   sr;
   logic [BCD_W-1:0]  bcd_adj;
   logic [DIGITS-1:0] blank_nxt;
   logic              zero_run;
   logic [BCD_W-1:0]  bcd_q;
   logic [DIGITS-1:0] blank_q;
   logic              out_valid_q;

   for (genvar k = 0; k < DIGITS; k++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit_in  (sr[WIDTH + DIGIT_W*k +: DIGIT_W]),
         .digit_out (bcd_adj[DIGIT_W*k +: DIGIT_W])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = SHIFT;
         SHIFT:   if (cnt == CNT_LAST) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready = 1'b0;
      if (state == IDLE) in_ready = ready_en;
   end

   assign accept = bus.in_valid && in_ready;

   // Holds in_ready low for the first cycle after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ready_en <= 1'b0;
      else        ready_en <= 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr  <= '0;
         cnt <= '0;
      end else if (accept) begin
         sr  <= {{BCD_W{1'b0}}, bus.in_data};
         cnt <= '0;
      end else if (state == SHIFT) begin
         sr  <= {bcd_adj, sr[WIDTH-1:0]} << 1;
         cnt <= cnt + 1'b1;
      end
   end

   // A digit is blank only if it and every more significant digit are zero.
   always_comb begin
      blank_nxt = '0;
      zero_run  = 1'b1;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         zero_run     = zero_run && (sr[WIDTH + DIGIT_W*k +: DIGIT_W] == '0);
         blank_nxt[k] = zero_run;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcd_q       <= '0;
         blank_q     <= BLANK_RST;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= (state == DONE);
         if (state == DONE) begin
            bcd_q   <= sr[SR_W-1:WIDTH];
            blank_q <= blank_nxt;
         end
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.bcd_out   = bcd_q;
   assign bus.blank_out = blank_q;
   assign bus.out_valid = out_valid_q;

endmodule
